// File: rtl/mem_access_unit.sv
// Core-side initiator for the word-wide data RAM bus: byte/half/word loads and stores,
// sub-word stores via read-modify-write. Optional trap on bad addresses: MEM_RANGE_TRAP_EN.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        req_fault;
  logic        mem_we_c;

`ifdef MEM_RANGE_TRAP_EN
  always_comb begin
    req_fault = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    if (req_size == 2'b01 && req_addr[0]) req_fault = 1'b1;
    if (req_size[1] && req_addr[1:0] != 2'b00) req_fault = 1'b1;
  end
`else
  assign req_fault = 1'b0;
`endif

  // Lane extraction and merge for the latched access.
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  always_comb begin
    shamt     = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    shifted   = mem_rdata >> shamt;
    lane_b    = shifted[7:0];
    lane_h    = shifted[15:0];
    unique case (size_q)
      2'b00:   load_val = signed_q ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      2'b01:   load_val = signed_q ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default: load_val = mem_rdata;
    endcase
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00ff << shamt;
      lane_data = {24'h0, wdata_q[7:0]} << shamt;
    end else begin
      lane_mask = 32'h0000_ffff << shamt;
      lane_data = {16'h0, wdata_q[15:0]} << shamt;
    end
    merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    signed_d  = signed_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    mem_we_c  = 1'b0;
    mem_wdata = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          fault_d  = req_fault;
          if (req_fault) begin
            rdata_d = 32'h0;
            state_d = StDone;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (!we_q) begin
          rdata_d = load_val;
          state_d = StDone;
        end else if (size_q[1]) begin
          mem_we_c  = 1'b1;
          mem_wdata = wdata_q;
          state_d   = StDone;
        end else begin
          merge_d = merged;
          state_d = StWrite;
        end
      end
      StWrite: begin
        mem_we_c  = 1'b1;
        mem_wdata = merge_q;
        state_d   = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // Write strobe is masked combinationally so a reset cycle never writes the RAM.
  assign mem_we   = mem_we_c & ~reset;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign rdata    = rdata_q;
`ifdef MEM_RANGE_TRAP_EN
  assign fault    = fault_q;
`else
  assign fault    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit with a 64-word behavioural RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, fault, mem_we;
  logic [31:0] rdata, mem_addr, mem_rdata, mem_wdata;
  logic [31:0] ram [64];

  int n_vec = 0;
  int n_err = 0;
  int lat, wes;
  logic [31:0] rd;
  logic        flt;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request at cycle 0; report done latency, write strobes seen, rdata/fault at done.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic hold,
                         output int o_lat, output int o_wes, output logic [31:0] o_rd,
                         output logic o_flt);
    req = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    o_lat = -1; o_wes = 0; o_rd = 32'h0; o_flt = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (!hold) req = 1'b0;
      if (mem_we) o_wes++;
      if (done) begin
        o_lat = c; o_rd = rdata; o_flt = fault;
        break;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4] = 32'h8899_AABB;
    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   {31'b0, busy},   32'h0);
    check("rst_done",   {31'b0, done},   32'h0);
    check("rst_rdata",  rdata,           32'h0);
    check("rst_fault",  {31'b0, fault},  32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_addr",   mem_addr,        32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, lat, wes, rd, flt);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_data", rd, 32'hFFFF_FFAA);
    check("lb_we", 32'(wes), 32'd0);
    run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, lat, wes, rd, flt);
    check("lbu_data", rd, 32'h0000_00AA);

    run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h5C, 1'b0, lat, wes, rd, flt);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_we", 32'(wes), 32'd1);
    check("sb_ram", ram[4], 32'h885C_AABB);

    run_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_F234, 1'b0, lat, wes, rd, flt);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_we", 32'(wes), 32'd1);
    check("sh_ram", ram[5], 32'hF234_0000);
    run_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0, lat, wes, rd, flt);
    check("lh_data", rd, 32'hFFFF_F234);
    run_req(1'b0, 2'b01, 1'b0, 32'h17, 32'h0, 1'b0, lat, wes, rd, flt);
    check("lhu_data", rd, 32'h0000_F234);

    run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b1, lat, wes, rd, flt);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we", 32'(wes), 32'd1);
    check("sw_ram", ram[8], 32'hDEAD_BEEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, lat, wes, rd, flt);
    check("lw_data", rd, 32'hDEAD_BEEF);

    // Reset lands on the WRITE cycle of a byte store.
    req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("rmw_write_we", {31'b0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_gate_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk); #1;
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_done", {31'b0, done}, 32'h0);
    check("rst_mid_ram", ram[4], 32'h885C_AABB);
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef MEM_RANGE_TRAP_EN
    run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, lat, wes, rd, flt);
    check("trap_mis_lat", 32'(lat), 32'd1);
    check("trap_mis_flt", {31'b0, flt}, 32'h1);
    check("trap_mis_we", 32'(wes), 32'd0);
    check("trap_mis_rd", rd, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, lat, wes, rd, flt);
    check("trap_rng_flt", {31'b0, flt}, 32'h1);
    run_req(1'b1, 2'b01, 1'b0, 32'h15, 32'h1234, 1'b0, lat, wes, rd, flt);
    check("trap_sh_we", 32'(wes), 32'd0);
    check("trap_sh_ram", ram[5], 32'hF234_0000);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, lat, wes, rd, flt);
    check("trap_clr_flt", {31'b0, flt}, 32'h0);
    check("trap_clr_rd", rd, 32'h885C_AABB);
`else
    run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, lat, wes, rd, flt);
    check("mis_lat", 32'(lat), 32'd2);
    check("mis_data", rd, 32'h885C_AABB);
    check("mis_flt", {31'b0, flt}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
